// File: rtl/ppu_pkg.sv
// ppu_pkg: shared definitions for the PPU CPU-facing register file.
//   - REG_* : register indices for the $2000-$2007 window (ri_sel_in value)
//   - mem_state_e : state encoding of the VRAM request/acknowledge FSM
//   - STAT_* : bit positions of the status flags in the $2002 read byte
package ppu_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [2:0] REG_SCROLL  = 3'd5;
  localparam logic [2:0] REG_ADDR    = 3'd6;
  localparam logic [2:0] REG_DATA    = 3'd7;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WR   = 2'd1,
    MEM_RD   = 2'd2
  } mem_state_e;

  localparam int STAT_VBLANK = 7;
  localparam int STAT_SPR0   = 6;
  localparam int STAT_OVF    = 5;

endpackage

// File: rtl/ppu_vram_port.sv
// ppu_vram_port: request/acknowledge FSM for PPU memory traffic.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_start_i          : start a write of wdata_i at addr_i (accepted only in IDLE)
//   rd_start_i          : start a read at addr_i (accepted only in IDLE)
//   mem_*_o             : address/data/requests, held stable until mem_ack_i
//   mem_ack_i           : completes the outstanding request (ignored in IDLE)
//   mem_rdata_i         : read data, valid with mem_ack_i
//   rd_valid_o/rd_data_o: read completion strobe and data (same cycle as ack)
//   busy_o              : a request is outstanding
module ppu_vram_port
  import ppu_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_start_i,
  input  logic              rd_start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_rdata_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_wr_req_o,
  output logic              mem_rd_req_o,
  output logic              rd_valid_o,
  output logic [7:0]        rd_data_o,
  output logic              busy_o
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      MEM_IDLE: begin
        if (wr_start_i) begin
          state_d = MEM_WR;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end else if (rd_start_i) begin
          state_d = MEM_RD;
          addr_d  = addr_i;
        end
      end
      MEM_WR, MEM_RD: begin
        if (mem_ack_i) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Requests decode straight from the state register, so reset drops them at once.
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_wr_req_o = (state_q == MEM_WR);
  assign mem_rd_req_o = (state_q == MEM_RD);
  assign busy_o       = (state_q != MEM_IDLE);
  assign rd_valid_o   = (state_q == MEM_RD) & mem_ack_i;
  assign rd_data_o    = mem_rdata_i;

endmodule

// File: rtl/ppu_regfile.sv
// ppu_regfile: CPU-facing $2000-$2007 register file of the PPU.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   ri_*                      : CPU register interface (select, level enable, r/nw, data)
//   ri_d_out                  : registered CPU read data
//   vblank_set_in/clr_in      : vblank start / pre-render line pulses
//   spr0_hit_in, spr_ovf_in   : status flag set pulses
//   nmi_out                   : ctrl[7] & vblank
//   ctrl_out, mask_out        : PPUCTRL / PPUMASK
//   v_out, t_out, fine_x_out  : loopy scroll state
//   oam_*                     : OAM address, write strobe/data, combinational read data
//   mem_*, busy_out           : VRAM request/ack bus for $2007 traffic
module ppu_regfile
  import ppu_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int OAM_AW  = 8,
  parameter int INC_FAR = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        ri_sel_in,
  input  logic              ri_cs_in,
  input  logic              ri_r_nw_in,
  input  logic [7:0]        ri_d_in,
  output logic [7:0]        ri_d_out,
  input  logic              vblank_set_in,
  input  logic              vblank_clr_in,
  input  logic              spr0_hit_in,
  input  logic              spr_ovf_in,
  output logic              nmi_out,
  output logic [7:0]        ctrl_out,
  output logic [7:0]        mask_out,
  output logic [14:0]       v_out,
  output logic [14:0]       t_out,
  output logic [2:0]        fine_x_out,
  output logic [OAM_AW-1:0] oam_addr_out,
  output logic              oam_we_out,
  output logic [7:0]        oam_wdata_out,
  input  logic [7:0]        oam_rdata_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [7:0]        mem_wdata_out,
  output logic              mem_wr_req_out,
  output logic              mem_rd_req_out,
  input  logic              mem_ack_in,
  input  logic [7:0]        mem_rdata_in,
  output logic              busy_out
);

  localparam logic [14:0] INC_FAR_V = 15'(INC_FAR);

  logic              cs_q;
  logic [7:0]        ctrl_q, ctrl_d;
  logic [7:0]        mask_q, mask_d;
  logic [14:0]       v_q, v_d;
  logic [14:0]       t_q, t_d;
  logic [2:0]        fine_x_q, fine_x_d;
  logic              w_q, w_d;
  logic [OAM_AW-1:0] oam_addr_q, oam_addr_d;
  logic              oam_we_q, oam_we_d;
  logic [7:0]        oam_wdata_q, oam_wdata_d;
  logic [7:0]        io_latch_q, io_latch_d;
  logic [7:0]        rd_buf_q, rd_buf_d;
  logic [7:0]        ri_d_q, ri_d_d;
  logic              vblank_q, vblank_d;
  logic              spr0_q, spr0_d;
  logic              ovf_q, ovf_d;

  logic              acc, wr_acc, rd_acc, status_rd, data_go;
  logic [7:0]        status_byte, rdata;
  logic              port_busy, port_rd_valid;
  logic [7:0]        port_rd_data;

  always_comb begin
    // One access per ri_cs_in assertion, taken on its rising level.
    acc       = ri_cs_in & ~cs_q;
    wr_acc    = acc & ~ri_r_nw_in;
    rd_acc    = acc & ri_r_nw_in;
    status_rd = rd_acc && (ri_sel_in == REG_STATUS);
    // $2007 accesses that arrive while a transaction is outstanding are dropped.
    data_go   = acc && (ri_sel_in == REG_DATA) && !port_busy;

    status_byte              = {3'b000, io_latch_q[4:0]};
    status_byte[STAT_VBLANK] = vblank_q;
    status_byte[STAT_SPR0]   = spr0_q;
    status_byte[STAT_OVF]    = ovf_q;

    case (ri_sel_in)
      REG_STATUS:  rdata = status_byte;
      REG_OAMDATA: rdata = oam_rdata_in;
      REG_DATA:    rdata = rd_buf_q;
      default:     rdata = io_latch_q;
    endcase

    ctrl_d      = ctrl_q;
    mask_d      = mask_q;
    v_d         = v_q;
    t_d         = t_q;
    fine_x_d    = fine_x_q;
    w_d         = w_q;
    oam_addr_d  = oam_addr_q;
    oam_we_d    = 1'b0;
    oam_wdata_d = oam_wdata_q;
    io_latch_d  = io_latch_q;
    rd_buf_d    = rd_buf_q;
    ri_d_d      = ri_d_q;

    // OAM address advances the cycle after the write strobe, so the strobe
    // cycle still presents the address being written.
    if (oam_we_q) oam_addr_d = oam_addr_q + OAM_AW'(1);

    if (rd_acc) begin
      ri_d_d     = rdata;
      io_latch_d = rdata;
    end

    if (wr_acc) begin
      io_latch_d = ri_d_in;
      case (ri_sel_in)
        REG_CTRL: begin
          ctrl_d       = ri_d_in;
          t_d[11:10]   = ri_d_in[1:0];
        end
        REG_MASK:    mask_d = ri_d_in;
        REG_OAMADDR: oam_addr_d = ri_d_in[OAM_AW-1:0];
        REG_OAMDATA: begin
          oam_we_d    = 1'b1;
          oam_wdata_d = ri_d_in;
        end
        REG_SCROLL: begin
          if (!w_q) begin
            t_d[4:0] = ri_d_in[7:3];
            fine_x_d = ri_d_in[2:0];
          end else begin
            t_d[9:5]   = ri_d_in[7:3];
            t_d[14:12] = ri_d_in[2:0];
          end
          w_d = ~w_q;
        end
        REG_ADDR: begin
          if (!w_q) begin
            t_d[13:8] = ri_d_in[5:0];
            t_d[14]   = 1'b0;
          end else begin
            t_d[7:0] = ri_d_in;
            v_d      = {t_q[14:8], ri_d_in};
          end
          w_d = ~w_q;
        end
        default: ;
      endcase
    end

    if (status_rd) w_d = 1'b0;

    if (data_go) v_d = v_q + (ctrl_q[2] ? INC_FAR_V : 15'd1);

    if (port_rd_valid) rd_buf_d = port_rd_data;

    // A status read wins over a same-cycle vblank set (NMI suppression);
    // the pre-render clear wins over everything.
    vblank_d = vblank_q;
    if (vblank_set_in) vblank_d = 1'b1;
    if (status_rd)     vblank_d = 1'b0;
    if (vblank_clr_in) vblank_d = 1'b0;

    spr0_d = spr0_q | spr0_hit_in;
    ovf_d  = ovf_q | spr_ovf_in;
    if (vblank_clr_in) begin
      spr0_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q        <= 1'b0;
      ctrl_q      <= '0;
      mask_q      <= '0;
      v_q         <= '0;
      t_q         <= '0;
      fine_x_q    <= '0;
      w_q         <= 1'b0;
      oam_addr_q  <= '0;
      oam_we_q    <= 1'b0;
      oam_wdata_q <= '0;
      io_latch_q  <= '0;
      rd_buf_q    <= '0;
      ri_d_q      <= '0;
      vblank_q    <= 1'b0;
      spr0_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cs_q        <= ri_cs_in;
      ctrl_q      <= ctrl_d;
      mask_q      <= mask_d;
      v_q         <= v_d;
      t_q         <= t_d;
      fine_x_q    <= fine_x_d;
      w_q         <= w_d;
      oam_addr_q  <= oam_addr_d;
      oam_we_q    <= oam_we_d;
      oam_wdata_q <= oam_wdata_d;
      io_latch_q  <= io_latch_d;
      rd_buf_q    <= rd_buf_d;
      ri_d_q      <= ri_d_d;
      vblank_q    <= vblank_d;
      spr0_q      <= spr0_d;
      ovf_q       <= ovf_d;
    end
  end

  ppu_vram_port #(
    .ADDR_W(ADDR_W)
  ) u_vram_port (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_start_i  (data_go & ~ri_r_nw_in),
    .rd_start_i  (data_go & ri_r_nw_in),
    .addr_i      (v_q[ADDR_W-1:0]),
    .wdata_i     (ri_d_in),
    .mem_ack_i   (mem_ack_in),
    .mem_rdata_i (mem_rdata_in),
    .mem_addr_o  (mem_addr_out),
    .mem_wdata_o (mem_wdata_out),
    .mem_wr_req_o(mem_wr_req_out),
    .mem_rd_req_o(mem_rd_req_out),
    .rd_valid_o  (port_rd_valid),
    .rd_data_o   (port_rd_data),
    .busy_o      (port_busy)
  );

  assign ri_d_out      = ri_d_q;
  assign nmi_out       = ctrl_q[7] & vblank_q;
  assign ctrl_out      = ctrl_q;
  assign mask_out      = mask_q;
  assign v_out         = v_q;
  assign t_out         = t_q;
  assign fine_x_out    = fine_x_q;
  assign oam_addr_out  = oam_addr_q;
  assign oam_we_out    = oam_we_q;
  assign oam_wdata_out = oam_wdata_q;
  assign busy_out      = port_busy;

endmodule

// File: tb/tb_ppu_regfile.sv
// tb_ppu_regfile: self-checking bench for ppu_regfile.
// Register-level behaviour is driven from a vector table; CPU read data and
// memory requests are checked through expectation queues filled at drive time.
module tb_ppu_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ri_sel;
  logic        ri_cs, ri_r_nw;
  logic [7:0]  ri_d;
  logic [7:0]  ri_d_out;
  logic        vblank_set, vblank_clr, spr0_hit, spr_ovf;
  logic        nmi;
  logic [7:0]  ctrl, mask;
  logic [14:0] v_out, t_out;
  logic [2:0]  fine_x;
  logic [7:0]  oam_addr, oam_wdata, oam_rdata;
  logic        oam_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_wr_req, mem_rd_req, mem_ack, busy;

  always #20 clk = ~clk;

  // OAM model: read data is a fixed function of the address.
  assign oam_rdata = oam_addr ^ 8'hA5;

  ppu_regfile #(.ADDR_W(14), .OAM_AW(8), .INC_FAR(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ri_sel_in(ri_sel), .ri_cs_in(ri_cs), .ri_r_nw_in(ri_r_nw), .ri_d_in(ri_d),
    .ri_d_out(ri_d_out),
    .vblank_set_in(vblank_set), .vblank_clr_in(vblank_clr),
    .spr0_hit_in(spr0_hit), .spr_ovf_in(spr_ovf),
    .nmi_out(nmi), .ctrl_out(ctrl), .mask_out(mask),
    .v_out(v_out), .t_out(t_out), .fine_x_out(fine_x),
    .oam_addr_out(oam_addr), .oam_we_out(oam_we), .oam_wdata_out(oam_wdata),
    .oam_rdata_in(oam_rdata),
    .mem_addr_out(mem_addr), .mem_wdata_out(mem_wdata),
    .mem_wr_req_out(mem_wr_req), .mem_rd_req_out(mem_rd_req),
    .mem_ack_in(mem_ack), .mem_rdata_in(mem_rdata), .busy_out(busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [7:0]  wdata;
  } mem_exp_t;

  logic [7:0] rd_q[$];
  mem_exp_t   mem_q[$];

  // One CPU access: assert cs for one cycle; returns just after the access edge.
  task automatic access(input logic [2:0] sel, input logic rnw, input logic [7:0] d,
                        input logic vset, input logic [7:0] exp_rd);
    logic [7:0] e;
    @(posedge clk); #1;
    ri_cs = 1'b1; ri_sel = sel; ri_r_nw = rnw; ri_d = d; vblank_set = vset;
    if (rnw) rd_q.push_back(exp_rd);
    @(posedge clk); #1;
    ri_cs = 1'b0; vblank_set = 1'b0;
    if (rnw) begin
      e = rd_q.pop_front();
      chk("ri_d_out", {24'd0, ri_d_out}, {24'd0, e});
    end
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] d);
    access(sel, 1'b0, d, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [2:0] sel, input logic [7:0] exp_rd);
    access(sel, 1'b1, 8'h00, 1'b0, exp_rd);
  endtask

  task automatic data_wr(input logic [13:0] addr, input logic [7:0] d);
    mem_q.push_back('{1'b1, addr, d});
    wr(3'd7, d);
  endtask

  task automatic data_rd(input logic [13:0] addr, input logic [7:0] exp_rd);
    mem_q.push_back('{1'b0, addr, 8'h00});
    rd(3'd7, exp_rd);
  endtask

  // Memory responder: wait (bounded) for a request, hold off 'lat' cycles,
  // compare against the queued expectation, then acknowledge for one cycle.
  task automatic serve_mem(input int lat, input logic [7:0] rdata);
    mem_exp_t e;
    int k;
    e = mem_q.pop_front();
    k = 0;
    while (!(mem_wr_req | mem_rd_req) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("mem_req_seen", {31'd0, mem_wr_req | mem_rd_req}, 32'd1);
    repeat (lat) begin @(posedge clk); #1; end
    chk("mem_wr_req", {31'd0, mem_wr_req}, {31'd0, e.wr});
    chk("mem_rd_req", {31'd0, mem_rd_req}, {31'd0, ~e.wr});
    chk("mem_addr", {18'd0, mem_addr}, {18'd0, e.addr});
    if (e.wr) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
    chk("busy_during_req", {31'd0, busy}, 32'd1);
    mem_ack = 1'b1; mem_rdata = rdata;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("req_drop_after_ack", {30'd0, mem_wr_req, mem_rd_req}, 32'd0);
    chk("busy_after_ack", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic        rnw;
    logic [7:0]  d;
    logic [7:0]  exp_rd;
    logic [14:0] exp_t;
    logic [14:0] exp_v;
    logic [2:0]  exp_fx;
    logic [7:0]  exp_ctrl;
    logic [7:0]  exp_mask;
    logic [7:0]  exp_oam;
    logic        exp_we;
  } vec_t;

  vec_t vec[16];

  initial begin
    mem_exp_t held;

    //        sel   rnw   d      rd     t         v         fx    ctrl   mask   oam    we
    vec[0]  = '{3'd5, 1'b0, 8'h7D, 8'h00, 15'h000F, 15'h0000, 3'd5, 8'h00, 8'h00, 8'h00, 1'b0};
    vec[1]  = '{3'd5, 1'b0, 8'h5E, 8'h00, 15'h616F, 15'h0000, 3'd5, 8'h00, 8'h00, 8'h00, 1'b0};
    vec[2]  = '{3'd5, 1'b0, 8'h7D, 8'h00, 15'h616F, 15'h0000, 3'd5, 8'h00, 8'h00, 8'h00, 1'b0};
    vec[3]  = '{3'd2, 1'b1, 8'h00, 8'h1D, 15'h616F, 15'h0000, 3'd5, 8'h00, 8'h00, 8'h00, 1'b0};
    vec[4]  = '{3'd5, 1'b0, 8'h13, 8'h00, 15'h6162, 15'h0000, 3'd3, 8'h00, 8'h00, 8'h00, 1'b0};
    vec[5]  = '{3'd0, 1'b0, 8'h03, 8'h00, 15'h6D62, 15'h0000, 3'd3, 8'h03, 8'h00, 8'h00, 1'b0};
    vec[6]  = '{3'd1, 1'b0, 8'h1E, 8'h00, 15'h6D62, 15'h0000, 3'd3, 8'h03, 8'h1E, 8'h00, 1'b0};
    vec[7]  = '{3'd0, 1'b1, 8'h00, 8'h1E, 15'h6D62, 15'h0000, 3'd3, 8'h03, 8'h1E, 8'h00, 1'b0};
    vec[8]  = '{3'd6, 1'b0, 8'h3F, 8'h00, 15'h6D3F, 15'h6D3F, 3'd3, 8'h03, 8'h1E, 8'h00, 1'b0};
    vec[9]  = '{3'd6, 1'b0, 8'hFF, 8'h00, 15'h3F3F, 15'h6D3F, 3'd3, 8'h03, 8'h1E, 8'h00, 1'b0};
    vec[10] = '{3'd6, 1'b0, 8'h08, 8'h00, 15'h3F08, 15'h3F08, 3'd3, 8'h03, 8'h1E, 8'h00, 1'b0};
    vec[11] = '{3'd3, 1'b0, 8'hFE, 8'h00, 15'h3F08, 15'h3F08, 3'd3, 8'h03, 8'h1E, 8'hFE, 1'b0};
    vec[12] = '{3'd4, 1'b0, 8'h55, 8'h00, 15'h3F08, 15'h3F08, 3'd3, 8'h03, 8'h1E, 8'hFE, 1'b1};
    vec[13] = '{3'd4, 1'b0, 8'h66, 8'h00, 15'h3F08, 15'h3F08, 3'd3, 8'h03, 8'h1E, 8'hFF, 1'b1};
    vec[14] = '{3'd4, 1'b1, 8'h00, 8'hA5, 15'h3F08, 15'h3F08, 3'd3, 8'h03, 8'h1E, 8'h00, 1'b0};
    vec[15] = '{3'd3, 1'b1, 8'h00, 8'hA5, 15'h3F08, 15'h3F08, 3'd3, 8'h03, 8'h1E, 8'h00, 1'b0};

    rst_n = 1'b0;
    ri_cs = 1'b0; ri_sel = 3'd0; ri_r_nw = 1'b0; ri_d = 8'h00;
    vblank_set = 1'b0; vblank_clr = 1'b0; spr0_hit = 1'b0; spr_ovf = 1'b0;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_ri_d_out", {24'd0, ri_d_out}, 32'd0);
    chk("rst_v_t", {2'd0, v_out, t_out}, 32'd0);
    chk("rst_ctrl_mask", {16'd0, ctrl, mask}, 32'd0);
    chk("rst_oam", {15'd0, oam_addr, oam_we, oam_wdata}, 32'd0);
    chk("rst_mem", {7'd0, mem_wr_req, mem_rd_req, busy, nmi, fine_x, mem_addr, 4'd0}, 32'd0);
    rd(3'd2, 8'h00);
    chk("rst_nmi", {31'd0, nmi}, 32'd0);

    // Table-driven register accesses
    for (int i = 0; i < 16; i++) begin
      access(vec[i].sel, vec[i].rnw, vec[i].d, 1'b0, vec[i].exp_rd);
      chk($sformatf("vec%0d_t", i), {17'd0, t_out}, {17'd0, vec[i].exp_t});
      chk($sformatf("vec%0d_v", i), {17'd0, v_out}, {17'd0, vec[i].exp_v});
      chk($sformatf("vec%0d_fine_x", i), {29'd0, fine_x}, {29'd0, vec[i].exp_fx});
      chk($sformatf("vec%0d_ctrl", i), {24'd0, ctrl}, {24'd0, vec[i].exp_ctrl});
      chk($sformatf("vec%0d_mask", i), {24'd0, mask}, {24'd0, vec[i].exp_mask});
      chk($sformatf("vec%0d_oam_addr", i), {24'd0, oam_addr}, {24'd0, vec[i].exp_oam});
      chk($sformatf("vec%0d_oam_we", i), {31'd0, oam_we}, {31'd0, vec[i].exp_we});
      if (vec[i].exp_we) chk($sformatf("vec%0d_oam_wdata", i), {24'd0, oam_wdata}, {24'd0, vec[i].d});
    end
    @(posedge clk); #1;
    chk("oam_no_inc_on_read", {24'd0, oam_addr}, 32'd0);

    // vblank / NMI
    wr(3'd0, 8'h80);
    chk("nmi_before_vblank", {31'd0, nmi}, 32'd0);
    @(posedge clk); #1; vblank_set = 1'b1;
    @(posedge clk); #1; vblank_set = 1'b0;
    chk("nmi_after_vblank", {31'd0, nmi}, 32'd1);
    rd(3'd2, 8'h80);
    chk("nmi_cleared_by_read", {31'd0, nmi}, 32'd0);
    access(3'd2, 1'b1, 8'h00, 1'b1, 8'h00);
    chk("nmi_suppressed", {31'd0, nmi}, 32'd0);
    @(posedge clk); #1;
    chk("nmi_suppressed_hold", {31'd0, nmi}, 32'd0);
    @(posedge clk); #1; spr0_hit = 1'b1; spr_ovf = 1'b1;
    @(posedge clk); #1; spr0_hit = 1'b0; spr_ovf = 1'b0;
    rd(3'd2, 8'h60);
    @(posedge clk); #1; vblank_clr = 1'b1; vblank_set = 1'b1; spr0_hit = 1'b1;
    @(posedge clk); #1; vblank_clr = 1'b0; vblank_set = 1'b0; spr0_hit = 1'b0;
    chk("clr_priority_nmi", {31'd0, nmi}, 32'd0);
    rd(3'd2, 8'h00);

    // $2007 write with a 3-cycle ack
    wr(3'd0, 8'h00);
    wr(3'd6, 8'h21);
    wr(3'd6, 8'h08);
    data_wr(14'h2108, 8'hAB);
    chk("v_post_inc_wr", {17'd0, v_out}, 32'h2109);
    serve_mem(3, 8'h00);

    // $2007 reads with far increment
    wr(3'd0, 8'h04);
    wr(3'd6, 8'h20);
    wr(3'd6, 8'h00);
    chk("v_load_2000", {17'd0, v_out}, 32'h2000);
    data_rd(14'h2000, 8'h00);
    chk("v_far_inc1", {17'd0, v_out}, 32'h2020);
    serve_mem(1, 8'h11);
    data_rd(14'h2020, 8'h11);
    serve_mem(0, 8'h22);
    chk("v_far_inc2", {17'd0, v_out}, 32'h2040);
    data_rd(14'h2040, 8'h22);
    serve_mem(2, 8'h33);

    // Accesses while busy are dropped; reset mid-transaction
    wr(3'd0, 8'h00);
    data_wr(14'h2060, 8'h5A);
    chk("v_busy_start", {17'd0, v_out}, 32'h2061);
    wr(3'd7, 8'h77);
    chk("v_unchanged_drop_wr", {17'd0, v_out}, 32'h2061);
    rd(3'd7, 8'h33);
    chk("v_unchanged_drop_rd", {17'd0, v_out}, 32'h2061);
    held = mem_q.pop_front();
    chk("held_wr_req", {31'd0, mem_wr_req}, {31'd0, held.wr});
    chk("held_addr", {18'd0, mem_addr}, {18'd0, held.addr});
    chk("held_wdata", {24'd0, mem_wdata}, {24'd0, held.wdata});
    @(posedge clk); #5;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {29'd0, mem_wr_req, mem_rd_req, busy}, 32'd0);
    chk("async_rst_v", {17'd0, v_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'h99;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("stale_ack_ignored", {29'd0, mem_wr_req, mem_rd_req, busy}, 32'd0);
    chk("rst_ri_d_out2", {24'd0, ri_d_out}, 32'd0);
    data_rd(14'h0000, 8'h00);
    serve_mem(0, 8'h44);
    chk("v_after_reset_rd", {17'd0, v_out}, 32'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
